captura_codigo_gray: RTL and testbench
======================================

CAPTURA_CODIGO_GRAY -- requirements
Module: captura_codigo_gray

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, SHALL set the number of consecutive stable cycles required before a code is accepted; legal range 1..2^20.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 gray_in  input  4  raw, asynchronous 4-bit Gray code from the switches.
REQ-005 bin  output  4  registered binary equivalent of the last accepted Gray code; this drives the LED stage bin input.
REQ-006 gray_q  output  4  last accepted Gray code, registered.
REQ-007 upd  output  1  one-cycle pulse, high in the cycle where bin/gray_q take a new value.
REQ-008 err  output  1  high when the last accepted code differed from the previous one in more than one bit.

Function
REQ-009 gray_in SHALL pass through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-010 Filter SHALL hold candidate register cand (4 bits) and counter cnt (width clog2(DEBOUNCE_CYCLES+1)).
REQ-011 States: ESTABLE (cand == gray_q, counting idle) and FILTRANDO (cand != gray_q, counting).
REQ-012 Each edge: if sync2 != cand, load cand <= sync2, cnt <= 0, next state FILTRANDO if sync2 != gray_q, else ESTABLE.
REQ-013 Each edge with sync2 == cand: cnt SHALL increment, saturating at DEBOUNCE_CYCLES.
REQ-014 Accept when state is FILTRANDO, sync2 == cand and cnt == DEBOUNCE_CYCLES-1: gray_q <= cand, bin <= gray-to-binary(cand), upd <= 1, next state ESTABLE.
REQ-015 Gray-to-binary: bin[3] = g[3]; bin[i] = bin[i+1] XOR g[i] for i = 2..0.
REQ-016 On accept, err <= 1 if popcount(cand XOR gray_q) > 1, else 0; err SHALL hold until the next accept.
REQ-017 upd SHALL be 0 in every cycle without an accept; never high two consecutive cycles.
REQ-018 Latency: a change sampled into sync1 at edge k and held stable SHALL appear on bin after edge k+DEBOUNCE_CYCLES+2.
REQ-019 A change lasting fewer than DEBOUNCE_CYCLES+... stable cycles in sync2 (i.e. shorter than required count) SHALL produce no upd and no change on bin/gray_q/err.
REQ-020 Returning to the accepted code while in FILTRANDO SHALL move to ESTABLE with no upd.
REQ-021 A stable input equal to gray_q SHALL never generate upd.

Reset
REQ-022 rst_n low SHALL immediately clear sync1, sync2, cand, cnt, gray_q, bin, upd, err to 0 and force ESTABLE, regardless of clock.
REQ-023 Reset asserted mid-filtering SHALL discard the pending candidate; after release, a new full stable period is required.
REQ-024 With gray_in = 0000 through reset release, no upd SHALL occur.

Structure
REQ-025 The gray-to-binary function, the popcount-greater-than-one check and the DEBOUNCE_CYCLES default SHALL live in a shared package/include used also by the LED stage bench.
REQ-026 The two-flop synchronizer SHALL be a separate sub-module, sincronizador_2ff, 4 bits wide, with clk/rst_n.
REQ-027 All outputs SHALL be driven directly from flops.

Verification (DEBOUNCE_CYCLES = 4)
REQ-028 Reset with gray_in = 0000, release, run 20 cycles -> bin = 0000, gray_q = 0000, upd never high, err = 0.
REQ-029 gray_in 0000 -> 0001 held -> bin = 0001 exactly after edge k+6, upd high one cycle, err = 0.
REQ-030 Walk all 16 Gray codes in order (0000,0001,0011,0010,...,1000), each held 10 cycles -> bin equals index 0..15, 16 -> 15 upd pulses, err always 0.
REQ-031 From accepted 0001, glitch to 0011 for 3 cycles then back to 0001 -> no upd, bin stays 0001.
REQ-032 From 0000 jump to 0101 held -> bin = 0110, err = 1; then 0111 held -> bin = 0101, err = 0.
REQ-033 Apply 0010 (bin 0011), assert rst_n low after 3 stable cycles, release -> all outputs 0 at once; upd = 1 only after 7 further cycles of stable 0010.

Source files
------------

// File: rtl/captura_codigo_gray_pkg.sv
// Shared definitions for the Gray-code capture block and the LED stage bench:
// debounce default, filter states and code helper functions.
package captura_codigo_gray_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;
  localparam int unsigned CODE_W                  = 4;

  typedef enum logic {
    ESTABLE   = 1'b0,
    FILTRANDO = 1'b1
  } estado_t;

  // MSB passes through; every lower bit folds in all bits above it.
  function automatic logic [CODE_W-1:0] gray_a_bin(input logic [CODE_W-1:0] g);
    logic [CODE_W-1:0] b;
    b[CODE_W-1] = g[CODE_W-1];
    for (int i = CODE_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic popcount_mayor_uno(input logic [CODE_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < CODE_W; i++) begin
      n += int'(v[i]);
    end
    return (n > 1);
  endfunction

endpackage

// File: rtl/captura_codigo_gray_sincronizador.sv
// Two-flop synchronizer for the raw switch bus; reset clears both stages.
module sincronizador_2ff
  import captura_codigo_gray_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] d,
  output logic [CODE_W-1:0] q1,
  output logic [CODE_W-1:0] q2
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1 <= '0;
      q2 <= '0;
    end else begin
      q1 <= d;
      q2 <= q1;
    end
  end

endmodule

// File: rtl/captura_codigo_gray.sv
// Debounced capture of a 4-bit Gray code from switches: synchronize, filter
// for DEBOUNCE_CYCLES stable cycles, then register code, binary value and flags.
module captura_codigo_gray
  import captura_codigo_gray_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] gray_in,
  output logic [3:0] bin,
  output logic [3:0] gray_q,
  output logic       upd,
  output logic       err
);

  localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    sync1, sync2;
  estado_t       state, state_n;
  logic [3:0]    cand, cand_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    gray_q_n, bin_n;
  logic          upd_n, err_n;

  sincronizador_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (gray_in),
    .q1    (sync1),
    .q2    (sync2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ESTABLE;
      cand   <= '0;
      cnt    <= '0;
      gray_q <= '0;
      bin    <= '0;
      upd    <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      cand   <= cand_n;
      cnt    <= cnt_n;
      gray_q <= gray_q_n;
      bin    <= bin_n;
      upd    <= upd_n;
      err    <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    cand_n   = cand;
    cnt_n    = cnt;
    gray_q_n = gray_q;
    bin_n    = bin;
    upd_n    = 1'b0;
    err_n    = err;
    if (sync2 != cand) begin
      // Any change restarts the count; returning to the accepted code is not a new candidate.
      cand_n  = sync2;
      cnt_n   = '0;
      state_n = (sync2 != gray_q) ? FILTRANDO : ESTABLE;
    end else begin
      if (cnt != CNT_MAX) begin
        cnt_n = cnt + 1'b1;
      end
      if (state == FILTRANDO && cnt == CNT_LAST) begin
        gray_q_n = cand;
        bin_n    = gray_a_bin(cand);
        err_n    = popcount_mayor_uno(cand ^ gray_q);
        upd_n    = 1'b1;
        state_n  = ESTABLE;
      end
    end
  end

endmodule

// File: tb/tb_captura_codigo_gray.sv
// Directed bench for captura_codigo_gray with the default debounce of 4 cycles.
module tb_captura_codigo_gray;

  logic       clk;
  logic       rst_n;
  logic [3:0] gray_in;
  logic [3:0] bin;
  logic [3:0] gray_q;
  logic       upd;
  logic       err;

  int unsigned n_tests;
  int unsigned n_fail;
  int unsigned upd_cnt;
  int unsigned upd_dbl;
  logic        upd_prev;
  int unsigned base;

  captura_codigo_gray #(.DEBOUNCE_CYCLES(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .gray_in (gray_in),
    .bin     (bin),
    .gray_q  (gray_q),
    .upd     (upd),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    upd_cnt  = 0;
    upd_dbl  = 0;
    upd_prev = 1'b0;
  end

  always @(negedge clk) begin
    if (upd) upd_cnt++;
    if (upd && upd_prev) upd_dbl++;
    upd_prev = upd;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    gray_in = 4'b0000;
    rst_n   = 1'b0;
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    gray_in = 4'b0000;
    rst_n   = 1'b0;
    #12;
    check_val("rst_bin", 32'(bin), 32'h0);
    check_val("rst_gray_q", 32'(gray_q), 32'h0);
    check_val("rst_upd", 32'(upd), 32'h0);
    check_val("rst_err", 32'(err), 32'h0);

    // Idle after reset with zero input
    @(negedge clk);
    rst_n = 1'b1;
    base  = upd_cnt;
    tick(20);
    check_val("idle_bin", 32'(bin), 32'h0);
    check_val("idle_gray_q", 32'(gray_q), 32'h0);
    check_val("idle_err", 32'(err), 32'h0);
    check_val("idle_upd_cnt", upd_cnt - base, 0);

    // Latency: gray_in sampled at edge k, bin updated after edge k+6
    gray_in = 4'b0001;
    tick(6);
    check_val("lat_bin_early", 32'(bin), 32'h0);
    check_val("lat_upd_early", 32'(upd), 32'h0);
    tick(1);
    check_val("lat_bin", 32'(bin), 32'h1);
    check_val("lat_upd", 32'(upd), 32'h1);
    check_val("lat_err", 32'(err), 32'h0);
    tick(1);
    check_val("lat_upd_pulse", 32'(upd), 32'h0);

    // Walk all Gray codes in sequence
    do_reset();
    base = upd_cnt;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] idx;
      idx     = 4'(i);
      gray_in = idx ^ (idx >> 1);
      tick(10);
      check_val($sformatf("walk_bin_%0d", i), 32'(bin), 32'(i));
      check_val($sformatf("walk_err_%0d", i), 32'(err), 32'h0);
    end
    check_val("walk_upd_cnt", upd_cnt - base, 15);

    // Short glitch must be filtered out
    do_reset();
    gray_in = 4'b0001;
    tick(10);
    check_val("glitch_pre_bin", 32'(bin), 32'h1);
    base    = upd_cnt;
    gray_in = 4'b0011;
    tick(3);
    gray_in = 4'b0001;
    tick(10);
    check_val("glitch_upd_cnt", upd_cnt - base, 0);
    check_val("glitch_bin", 32'(bin), 32'h1);
    check_val("glitch_gray_q", 32'(gray_q), 32'h1);

    // Multi-bit jump flags err, single-bit step clears it
    do_reset();
    gray_in = 4'b0101;
    tick(10);
    check_val("jump_bin", 32'(bin), 32'h6);
    check_val("jump_gray_q", 32'(gray_q), 32'h5);
    check_val("jump_err", 32'(err), 32'h1);
    gray_in = 4'b0111;
    tick(10);
    check_val("step_bin", 32'(bin), 32'h5);
    check_val("step_err", 32'(err), 32'h0);

    // Reset during filtering discards the candidate
    do_reset();
    gray_in = 4'b0101;
    tick(10);
    check_val("mid_pre_err", 32'(err), 32'h1);
    gray_in = 4'b0010;
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_bin", 32'(bin), 32'h0);
    check_val("mid_rst_gray_q", 32'(gray_q), 32'h0);
    check_val("mid_rst_err", 32'(err), 32'h0);
    check_val("mid_rst_upd", 32'(upd), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(6);
    check_val("mid_upd_early", 32'(upd), 32'h0);
    check_val("mid_bin_early", 32'(bin), 32'h0);
    tick(1);
    check_val("mid_upd", 32'(upd), 32'h1);
    check_val("mid_bin", 32'(bin), 32'h3);

    tick(2);
    check_val("upd_double", upd_dbl, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
